// File: rtl/led_cmd_if.sv
// Command channel for led_blink_sequencer: valid/ready handshake carrying mode and blink count.
interface led_cmd_if #(
    parameter int CNT_W = 4
);
    logic             i_CMD_VALID;
    logic             o_CMD_READY;
    logic [1:0]       i_CMD_MODE;
    logic [CNT_W-1:0] i_CMD_COUNT;

    modport master (output i_CMD_VALID, i_CMD_MODE, i_CMD_COUNT, input o_CMD_READY);
    modport slave  (input  i_CMD_VALID, i_CMD_MODE, i_CMD_COUNT, output o_CMD_READY);
endinterface

// File: rtl/led_blink_sequencer.sv
// Command-driven LED controller: steady off/on, N counted blinks or continuous blink.
// Optional LED_PWM_DIM_EN: dims lit states with a duty taken from the prescaler low byte.
module led_blink_sequencer #(
    parameter int PRESCALE_W  = 16,
    parameter int PHASE_TICKS = 8,
    parameter int CNT_W       = 4,
    parameter int DIM_DUTY    = 64
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    led_cmd_if.slave    cmd,
    output logic        o_LED,
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_TICK
);
    localparam int PH_W = $clog2(PHASE_TICKS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    localparam logic [1:0] M_OFF  = 2'd0;
    localparam logic [1:0] M_ON   = 2'd1;
    localparam logic [1:0] M_BN   = 2'd2;
    localparam logic [1:0] M_BC   = 2'd3;

    if (PHASE_TICKS < 1) begin : g_bad_phase
        $error("PHASE_TICKS must be >= 1");
    end
    if (DIM_DUTY < 0 || DIM_DUTY > 255) begin : g_bad_duty
        $error("DIM_DUTY must be within 0..255");
    end
`ifdef LED_PWM_DIM_EN
    if (PRESCALE_W < 8) begin : g_bad_prescale
        $error("PRESCALE_W must be >= 8 when dimming is enabled");
    end
`endif

    logic [PRESCALE_W-1:0] prescaler, pre_nxt;
    logic [1:0]            state;
    logic                  steady, cont;
    logic [PH_W-1:0]       phase_cnt;
    logic [CNT_W-1:0]      remaining;
    logic                  accept, tick, phase_end, on_val;

    assign cmd.o_CMD_READY = (state == S_IDLE) | cont;
    assign accept    = cmd.i_CMD_VALID & cmd.o_CMD_READY;
    assign tick      = &prescaler;
    assign phase_end = tick && (state != S_IDLE) && (phase_cnt == PH_W'(PHASE_TICKS - 1));
    // Any blink command restarts the prescaler so the first phase is full length.
    assign pre_nxt   = (accept && cmd.i_CMD_MODE[1]) ? '0 : prescaler + PRESCALE_W'(1);
    assign o_TICK    = tick;

`ifdef LED_PWM_DIM_EN
    // Judged against the prescaler value the LED register will sit alongside.
    assign on_val = (pre_nxt[7:0] < 8'(DIM_DUTY));
`else
    assign on_val = 1'b1;
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            prescaler <= '0;
            state     <= S_IDLE;
            steady    <= 1'b0;
            cont      <= 1'b0;
            phase_cnt <= '0;
            remaining <= '0;
            o_LED     <= 1'b0;
            o_BUSY    <= 1'b0;
            o_DONE    <= 1'b0;
        end else begin
            prescaler <= pre_nxt;
            o_DONE    <= 1'b0;
            if (accept) begin
                // A command accepted mid-blink drops the current phase without a done pulse.
                phase_cnt <= '0;
                unique case (cmd.i_CMD_MODE)
                    M_OFF, M_ON: begin
                        state  <= S_IDLE;
                        steady <= cmd.i_CMD_MODE[0];
                        cont   <= 1'b0;
                        o_LED  <= cmd.i_CMD_MODE[0] & on_val;
                        o_BUSY <= 1'b0;
                    end
                    M_BN: begin
                        cont <= 1'b0;
                        if (cmd.i_CMD_COUNT == '0) begin
                            state  <= S_IDLE;
                            steady <= 1'b0;
                            o_LED  <= 1'b0;
                            o_BUSY <= 1'b0;
                            o_DONE <= 1'b1;
                        end else begin
                            state     <= S_ON;
                            remaining <= cmd.i_CMD_COUNT;
                            o_LED     <= on_val;
                            o_BUSY    <= 1'b1;
                        end
                    end
                    M_BC: begin
                        state  <= S_ON;
                        cont   <= 1'b1;
                        o_LED  <= on_val;
                        o_BUSY <= 1'b1;
                    end
                endcase
            end else begin
                if (tick && state != S_IDLE)
                    phase_cnt <= phase_end ? '0 : phase_cnt + PH_W'(1);
                case (state)
                    S_IDLE: o_LED <= steady & on_val;
                    S_ON: begin
                        if (phase_end) begin
                            state <= S_OFF;
                            o_LED <= 1'b0;
                        end else begin
                            o_LED <= on_val;
                        end
                    end
                    S_OFF: begin
                        o_LED <= 1'b0;
                        if (phase_end) begin
                            if (cont || remaining > CNT_W'(1)) begin
                                state <= S_ON;
                                o_LED <= on_val;
                                if (!cont)
                                    remaining <= remaining - CNT_W'(1);
                            end else begin
                                state  <= S_IDLE;
                                steady <= 1'b0;
                                o_BUSY <= 1'b0;
                                o_DONE <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        cont   <= 1'b0;
                        o_LED  <= 1'b0;
                        o_BUSY <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_blink_sequencer.sv
// Randomized + directed scoreboard bench for led_blink_sequencer (small prescaler build).
module tb_led_blink_sequencer;
    localparam int PW = 2;
    localparam int PT = 2;
    localparam int CW = 4;
    localparam int PL = PT * (1 << PW);   // clocks per blink phase

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_cmd_if #(.CNT_W(CW)) cmd_if();
    logic led, busy, done, tick;

    led_blink_sequencer #(.PRESCALE_W(PW), .PHASE_TICKS(PT), .CNT_W(CW), .DIM_DUTY(64)) dut (
        .i_CLK(clk), .i_RST(rst), .cmd(cmd_if),
        .o_LED(led), .o_BUSY(busy), .o_DONE(done), .o_TICK(tick)
    );

    typedef struct {
        int   n;
        logic led, busy, ready, done, tick;
    } exp_t;
    exp_t q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: describes the current cycle by when the active blink began.
    int n = 0, pre = 0, bstart = 0, bcount = 0;
    bit steady = 0, active = 0, bcont = 0, done_m = 0;

    task automatic chk(string name, int cyc, logic act, logic exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic cycle(bit r, bit v, logic [1:0] m, int c);
        exp_t e;
        bit   acc;
        @(negedge clk);
        e.n     = n;
        e.led   = active ? (((n - bstart) / PL) % 2 == 0) : steady;
        e.busy  = active;
        e.ready = !active || bcont;
        e.done  = done_m;
        e.tick  = (pre == (1 << PW) - 1);
        q.push_back(e);
        rst = r;
        cmd_if.i_CMD_VALID = v;
        cmd_if.i_CMD_MODE  = m;
        cmd_if.i_CMD_COUNT = CW'(c);
        acc    = v && e.ready && !r;
        done_m = 0;
        pre    = (pre + 1) % (1 << PW);
        if (r) begin
            pre = 0; steady = 0; active = 0; bcont = 0;
        end else if (acc) begin
            case (m)
                2'd0, 2'd1: begin active = 0; bcont = 0; steady = m[0]; end
                2'd2: begin
                    pre = 0; bcont = 0;
                    if (c == 0) begin active = 0; steady = 0; done_m = 1; end
                    else begin active = 1; bcount = c; bstart = n + 1; end
                end
                default: begin pre = 0; active = 1; bcont = 1; bstart = n + 1; end
            endcase
        end else if (active && !bcont && (n - bstart) == 2 * PL * bcount - 1) begin
            active = 0; steady = 0; done_m = 1;
        end
        n++;
    endtask

    task automatic idle(int k);
        repeat (k) cycle(0, 0, 2'd0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("led",   e.n, led,                e.led);
                chk("busy",  e.n, busy,               e.busy);
                chk("ready", e.n, cmd_if.o_CMD_READY, e.ready);
                chk("done",  e.n, done,               e.done);
                chk("tick",  e.n, tick,               e.tick);
            end
        end
    end

    initial begin
        bit         r, v;
        logic [1:0] m;
        int         c;
        cmd_if.i_CMD_VALID = 1'b0;
        cmd_if.i_CMD_MODE  = 2'd0;
        cmd_if.i_CMD_COUNT = '0;
        @(posedge clk);
        cycle(1, 0, 2'd0, 0);
        cycle(1, 0, 2'd0, 0);
        idle(20);
        // steady on then off
        cycle(0, 1, 2'd1, 0); idle(4); cycle(0, 1, 2'd0, 0); idle(3);
        // three counted blinks, then the zero-count case
        cycle(0, 1, 2'd2, 3); idle(52);
        cycle(0, 1, 2'd2, 0); idle(3);
        // continuous blink preempted by steady on during an OFF phase
        cycle(0, 1, 2'd3, 0); idle(10); cycle(0, 1, 2'd1, 0); idle(5);
        // command accepted in the done cycle of a single blink
        cycle(0, 1, 2'd2, 1); idle(16); cycle(0, 1, 2'd1, 0); idle(4);
        // reset mid-blink, requester keeps valid high while not ready
        cycle(0, 1, 2'd2, 5); repeat (19) cycle(0, 1, 2'd3, 0);
        cycle(1, 0, 2'd0, 0); idle(5);
        // maximum count
        cycle(0, 1, 2'd2, 15); idle(245);
        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(0, 399) == 0);
            v = ($urandom_range(0, 9) == 0);
            m = 2'($urandom_range(0, 3));
            c = ($urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 3));
            cycle(r, v, m, c);
        end
        @(negedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
